// File: rtl/present_encryptor_param.sv
// PRESENT-64 block encryptor, 80- or 128-bit key, iterative one round per clock.
// Latency: out_valid_o rises ROUNDS edges after the accept edge; one block in flight at a time.
// Backpressure: in_ready_o low outside IDLE or during key load; result held in DONE until out_ready_i.
module present_encryptor_param #(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic                 key_load_i,
    input  logic [63:0]          data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [63:0]          data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    // Reject unsupported configurations at elaboration time.
    if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
        $error("present_encryptor_param: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_encryptor_param: ROUNDS must be in 1..31");
    end

    localparam logic [4:0] LP_LAST_ROUND = 5'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_fsm;
    state_t                 w_fsm_next;
    logic [KEY_WIDTH-1:0]   r_mkey;
    logic [KEY_WIDTH-1:0]   r_wkey;
    logic [63:0]            r_state;
    logic [4:0]             r_cnt;

    logic                   w_accept;
    logic                   w_done_hs;
    logic [63:0]            w_round_key;
    logic [63:0]            w_round_out;
    logic [KEY_WIDTH-1:0]   w_key_rot;
    logic [KEY_WIDTH-1:0]   w_key_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = sbox(d[4*n +: 4]);
        end
        return o;
    endfunction

    // Bit i moves to (16*i) mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            o[(16 * i) % 63] = d[i];
        end
        o[63] = d[63];
        return o;
    endfunction

    // Round key is always the top 64 bits of the working key.
    assign w_round_key = r_wkey[KEY_WIDTH-1 -: 64];
    assign w_round_out = p_layer(s_layer(r_state ^ w_round_key));

    // Key schedule step differs only in S-box count and counter position.
    if (KEY_WIDTH == 128) begin : g_ks128
        assign w_key_rot  = {r_wkey[66:0], r_wkey[127:67]};
        assign w_key_next = {sbox(w_key_rot[127:124]), sbox(w_key_rot[123:120]),
                             w_key_rot[119:67], w_key_rot[66:62] ^ r_cnt,
                             w_key_rot[61:0]};
    end else begin : g_ks80
        assign w_key_rot  = {r_wkey[18:0], r_wkey[79:19]};
        assign w_key_next = {sbox(w_key_rot[79:76]), w_key_rot[75:20],
                             w_key_rot[19:15] ^ r_cnt, w_key_rot[14:0]};
    end

    assign w_accept  = in_valid_i & in_ready_o;
    assign w_done_hs = (r_fsm == S_DONE) & out_ready_i;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_accept) w_fsm_next = S_RUN;
            S_RUN:   if (r_cnt == LP_LAST_ROUND) w_fsm_next = S_DONE;
            S_DONE:  if (w_done_hs) w_fsm_next = S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // FSM outputs; ciphertext gets final whitening and is zero while not valid.
    always_comb begin
        in_ready_o  = 1'b0;
        busy_o      = 1'b0;
        out_valid_o = 1'b0;
        data_o      = '0;
        case (r_fsm)
            S_IDLE: in_ready_o = ~key_load_i;
            S_RUN:  busy_o     = 1'b1;
            S_DONE: begin
                out_valid_o = 1'b1;
                data_o      = r_state ^ w_round_key;
            end
            default: ;
        endcase
    end

    // Master key register; loads in any state without disturbing the block in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mkey <= '0;
        end else if (key_load_i) begin
            r_mkey <= key_i;
        end
    end

    // Datapath: capture block on accept, one cipher round per RUN edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= '0;
            r_wkey  <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= data_i;
            r_wkey  <= r_mkey;
            r_cnt   <= 5'd1;
        end else if (r_fsm == S_RUN) begin
            r_state <= w_round_out;
            r_wkey  <= w_key_next;
            r_cnt   <= r_cnt + 5'd1;
        end
    end

endmodule

// File: tb/tb_present_encryptor_param.sv
// Directed bench for present_encryptor_param with published PRESENT test vectors.
// Exercises both key widths, latency, key-load priority, DONE hold and mid-run reset.
// Expected values are fixed constants from the PRESENT reference vectors.
module tb_present_encryptor_param;

    logic         clk;
    logic         rst_n;

    logic [79:0]  key80;
    logic         kl80;
    logic [63:0]  din80;
    logic         iv80;
    logic         ir80;
    logic [63:0]  dout80;
    logic         ov80;
    logic         or80;
    logic         busy80;

    logic [127:0] key128;
    logic         kl128;
    logic [63:0]  din128;
    logic         iv128;
    logic         ir128;
    logic [63:0]  dout128;
    logic         ov128;
    logic         or128;
    logic         busy128;

    int n_cmp = 0;
    int n_err = 0;

    present_encryptor_param #(.KEY_WIDTH(80), .ROUNDS(31)) u_dut80 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_i       (key80),
        .key_load_i  (kl80),
        .data_i      (din80),
        .in_valid_i  (iv80),
        .in_ready_o  (ir80),
        .data_o      (dout80),
        .out_valid_o (ov80),
        .out_ready_i (or80),
        .busy_o      (busy80)
    );

    present_encryptor_param #(.KEY_WIDTH(128), .ROUNDS(31)) u_dut128 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_i       (key128),
        .key_load_i  (kl128),
        .data_i      (din128),
        .in_valid_i  (iv128),
        .in_ready_o  (ir128),
        .data_o      (dout128),
        .out_valid_o (ov128),
        .out_ready_i (or128),
        .busy_o      (busy128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block on the selected DUT and wait for out_valid (bounded).
    // When load_at >= 0, pulse key_load on the 80-bit DUT at that cycle of the run.
    task automatic run_block(input bit sel, input logic [63:0] pt, input int load_at,
                             output logic [63:0] ct, output int lat);
        if (sel) begin din128 = pt; iv128 = 1'b1; end
        else     begin din80  = pt; iv80  = 1'b1; end
        tick();
        iv80  = 1'b0;
        iv128 = 1'b0;
        lat   = 0;
        while (!(sel ? ov128 : ov80) && lat < 100) begin
            kl80 = (lat == load_at);
            tick();
            lat++;
        end
        kl80 = 1'b0;
        ct   = sel ? dout128 : dout80;
    endtask

    task automatic handshake(input bit sel);
        if (sel) or128 = 1'b1; else or80 = 1'b1;
        tick();
        or80  = 1'b0;
        or128 = 1'b0;
    endtask

    initial begin
        logic [63:0] ct;
        logic [63:0] held;
        int          lat;
        int          bad;

        rst_n = 1'b0;
        key80 = '0;  kl80 = 1'b0;  din80 = '0;  iv80 = 1'b0;  or80 = 1'b0;
        key128 = '0; kl128 = 1'b0; din128 = '0; iv128 = 1'b0; or128 = 1'b0;
        #12;
        check("rst_in_ready",  64'(ir80),   64'd1);
        check("rst_out_valid", 64'(ov80),   64'd0);
        check("rst_data",      dout80,      64'd0);
        check("rst_busy",      64'(busy80), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Default all-zero master key, with an all-ones key load during the run.
        key80 = {80{1'b1}};
        din80 = 64'h0;
        iv80  = 1'b1;
        tick();
        iv80  = 1'b0;
        check("run_busy",     64'(busy80), 64'd1);
        check("run_in_ready", 64'(ir80),   64'd0);
        lat = 1;
        while (!ov80 && lat < 100) begin
            kl80 = (lat == 5);
            tick();
            lat++;
        end
        kl80 = 1'b0;
        lat  = lat - 1;
        check("k0_latency", 64'(lat), 64'd31);
        check("k0_ct",      dout80,   64'h5579C1387B228445);

        // Result held while the consumer stalls.
        held = dout80;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dout80 !== held || ov80 !== 1'b1) bad++;
        end
        check("done_hold_unstable", 64'(bad), 64'd0);
        check("done_in_ready",      64'(ir80), 64'd0);
        handshake(1'b0);
        check("hs_out_valid", 64'(ov80), 64'd0);
        check("hs_data_zero", dout80,    64'd0);
        check("hs_in_ready",  64'(ir80), 64'd1);

        // Key loaded mid-run now applies.
        run_block(1'b0, 64'hFFFFFFFFFFFFFFFF, -1, ct, lat);
        check("kF_ptF_latency", 64'(lat), 64'd31);
        check("kF_ptF_ct",      ct,       64'h3333DCD3213210D2);
        handshake(1'b0);
        run_block(1'b0, 64'h0, -1, ct, lat);
        check("kF_pt0_ct",      ct,       64'hE72C46C0F5945049);
        handshake(1'b0);

        // Key load and valid together: load wins, block not accepted.
        key80 = '0;
        kl80  = 1'b1;
        din80 = 64'hFFFFFFFFFFFFFFFF;
        iv80  = 1'b1;
        #1;
        check("kl_prio_in_ready", 64'(ir80), 64'd0);
        tick();
        kl80 = 1'b0;
        iv80 = 1'b0;
        check("kl_prio_not_busy", 64'(busy80), 64'd0);
        run_block(1'b0, 64'h0, -1, ct, lat);
        check("kl_prio_new_key_ct", ct, 64'h5579C1387B228445);
        handshake(1'b0);

        // Reset in the middle of a run aborts the block.
        key80 = {80{1'b1}};
        kl80  = 1'b1;
        tick();
        kl80  = 1'b0;
        din80 = 64'h0123456789ABCDEF;
        iv80  = 1'b1;
        tick();
        iv80  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #2;
        check("midrst_in_ready",  64'(ir80),   64'd1);
        check("midrst_out_valid", 64'(ov80),   64'd0);
        check("midrst_data",      dout80,      64'd0);
        check("midrst_busy",      64'(busy80), 64'd0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ov80 !== 1'b0 || busy80 !== 1'b0) bad++;
        end
        check("midrst_no_output", 64'(bad), 64'd0);
        // Reset also cleared the master key back to zero.
        run_block(1'b0, 64'h0, -1, ct, lat);
        check("post_rst_key0_ct", ct, 64'h5579C1387B228445);
        handshake(1'b0);

        // 128-bit key variant.
        run_block(1'b1, 64'h0, -1, ct, lat);
        check("k128_latency", 64'(lat), 64'd31);
        check("k128_ct",      ct,       64'h96DB702A2E6900AF);
        handshake(1'b1);
        check("k128_hs_in_ready", 64'(ir128), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/present_encryptor_param.md
PRESENT_ENCRYPTOR_PARAM -- requirements
Module: present_encryptor_param

Interface
REQ-001 Parameter KEY_WIDTH, default 80, PRESENT key size; legal values 80 and 128 only, any other value is an elaboration error.
REQ-002 Parameter ROUNDS, default 31, number of round iterations; legal range 1..31, any other value is an elaboration error.
REQ-003 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 key_i  input  KEY_WIDTH  master key value.
REQ-006 key_load_i  input  1  writes key_i into the master key register.
REQ-007 data_i  input  64  plaintext block.
REQ-008 in_valid_i  input  1  plaintext-side valid.
REQ-009 in_ready_o  output  1  plaintext-side ready.
REQ-010 data_o  output  64  ciphertext.
REQ-011 out_valid_o  output  1  ciphertext valid.
REQ-012 out_ready_i  input  1  ciphertext consumed.
REQ-013 busy_o  output  1  round iteration in progress.

Function
REQ-014 FSM states: IDLE, RUN, DONE; registers: master key (KEY_WIDTH), working key (KEY_WIDTH), state (64), round counter (5 bits).
REQ-015 Master key: key_load_i=1 loads key_i on the edge in any FSM state; working key and the in-flight block are unaffected.
REQ-016 in_ready_o = (FSM==IDLE) & ~key_load_i; key load has priority over block acceptance in the same cycle.
REQ-017 Accept (in_valid_i & in_ready_o at an edge): state<=data_i, working key<=master key, counter<=1, FSM->RUN.
REQ-018 Each RUN edge: state<=pLayer(sLayer(state ^ wkey[KW-1:KW-64])); wkey<=key_update(wkey, counter); counter<=counter+1.
REQ-019 sLayer: PRESENT S-box {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} on all 16 nibbles; pLayer: bit i -> bit (16*i) mod 63 for i<63, bit 63 fixed.
REQ-020 key_update, KW=80: rotate left 61; S-box on bits[79:76]; bits[19:15] ^= counter.
REQ-021 key_update, KW=128: rotate left 61; S-box on bits[127:124] and [123:120]; bits[66:62] ^= counter.
REQ-022 RUN edge with counter==ROUNDS: FSM->DONE; exactly ROUNDS RUN edges per block.
REQ-023 DONE: out_valid_o=1, data_o = state ^ wkey[KW-1:KW-64] (final whitening), held stable until handshake.
REQ-024 data_o = 0 whenever out_valid_o=0.
REQ-025 DONE & out_ready_i at edge: FSM->IDLE; no plaintext accepted in that same cycle (in_ready_o is 0 in DONE).
REQ-026 Latency: out_valid_o rises after ROUNDS edges following the accept edge; throughput one block per ROUNDS+2 cycles minimum.
REQ-027 busy_o = (FSM==RUN).
REQ-028 in_valid_i ignored outside IDLE; out_ready_i ignored outside DONE.
REQ-029 Block accepted before any key load uses the all-zero master key.

Reset
REQ-030 rst_ni=0 asynchronously forces FSM=IDLE and clears master key, working key, state and counter to 0; outputs: in_ready_o=1 (with key_load_i=0), out_valid_o=0, data_o=0, busy_o=0.
REQ-031 Reset mid-RUN or in DONE aborts the block; no ciphertext is produced for it after release.

Verification
REQ-032 KW=80: key 0, pt 0000000000000000 -> data_o 5579C1387B228445 exactly 31 edges after accept.
REQ-033 KW=80: key FFFF...FF, pt FFFFFFFFFFFFFFFF -> 3333DCD3213210D2; then pt 0 with same key, no reload -> E72C46C0F5945049.
REQ-034 KW=128: key 0, pt 0 -> 96DB702A2E6900AF.
REQ-035 Key load of FF..FF during RUN for block (key 0, pt 0) -> result still 5579C1387B228445; next block uses the new key.
REQ-036 key_load_i and in_valid_i both high in IDLE -> key loaded, block not accepted, in_ready_o=0 that cycle.
REQ-037 Hold out_ready_i=0 for 10 cycles in DONE -> data_o/out_valid_o stable; rst_ni pulse mid-RUN -> all outputs at reset values, FSM IDLE.
